// File: rtl/sw_pkg.sv
// sw_pkg: shared types and constants for the Smith-Waterman front end.
// Base encodings, FSM state enum, default sizes and the biased-zero score.
package sw_pkg;

  localparam int DEF_SCORE_WIDTH = 12;
  localparam int DEF_LENGTH      = 128;

  localparam logic [1:0] BASE_T = 2'b00;
  localparam logic [1:0] BASE_C = 2'b01;
  localparam logic [1:0] BASE_A = 2'b10;
  localparam logic [1:0] BASE_G = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_RESULT
  } sw_state_e;

  // Scores are biased: the array's zero sits at 2^(width-1).
  function automatic logic [31:0] zero_score(input int width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/sw_drain_timer.sv
// sw_drain_timer: loadable down-counter bounding the array drain wait.
// zero flags the cycle whose decrement brings the count to 0.
module sw_drain_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = dec && (cnt <= W'(1));

endmodule

// File: rtl/sw_stream_controller.sv
// sw_stream_controller: feeds a target stream into the SW scoring array
// and returns the selected PE's score. Option: SW_MAX_TGT_CHECK_EN.
module sw_stream_controller
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = DEF_SCORE_WIDTH,
  parameter int LENGTH      = DEF_LENGTH,
  parameter int LOG_LENGTH  = $clog2(LENGTH),
  parameter int LEN_WIDTH   = 16,
  parameter int DRAIN_SLACK = 4,
  parameter int MAX_TGT     = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LOG_LENGTH:0]    query_len,
  input  logic                   tgt_valid,
  output logic                   tgt_ready,
  input  logic [1:0]             tgt_data,
  input  logic                   tgt_last,
  output logic                   sa_en,
  output logic [1:0]             sa_data,
  output logic [LOG_LENGTH-1:0]  sa_select,
  input  logic [SCORE_WIDTH-1:0] sa_result,
  input  logic                   sa_vld,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [SCORE_WIDTH-1:0] res_score,
  output logic [LEN_WIDTH-1:0]   res_len,
  output logic                   res_err,
  output logic                   busy
);

  localparam int TW = $clog2(LENGTH + DRAIN_SLACK + 1);
  localparam logic [SCORE_WIDTH-1:0] ZERO =
    SCORE_WIDTH'(zero_score(SCORE_WIDTH));
  localparam logic [LOG_LENGTH:0] QMAX = (LOG_LENGTH+1)'(LENGTH);

  sw_state_e          state;
  logic [LOG_LENGTH:0] q_len;
  logic [LOG_LENGTH:0] ql_eff;
  logic                tmr_zero;
  logic                accept;

  assign ql_eff = (query_len > QMAX) ? QMAX : query_len;
  assign accept = tgt_valid && tgt_ready;

  sw_drain_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_LOAD),
    .dec      (state == ST_DRAIN),
    .load_val (TW'(q_len) + TW'(DRAIN_SLACK)),
    .zero     (tmr_zero)
  );

`ifdef SW_MAX_TGT_CHECK_EN
  logic drop;
  logic over;
  assign over = res_len >= LEN_WIDTH'(MAX_TGT);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tgt_ready <= 1'b0;
      sa_en     <= 1'b0;
      sa_data   <= BASE_T;
      sa_select <= '0;
      q_len     <= '0;
      res_valid <= 1'b0;
      res_score <= '0;
      res_len   <= '0;
      res_err   <= 1'b0;
      busy      <= 1'b0;
`ifdef SW_MAX_TGT_CHECK_EN
      drop      <= 1'b0;
`endif
    end else begin
      sa_en <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start && query_len != '0) begin
            state     <= ST_LOAD;
            busy      <= 1'b1;
            tgt_ready <= 1'b1;
            sa_select <= LOG_LENGTH'(ql_eff - 1'b1);
            q_len     <= ql_eff;
            res_len   <= '0;
            res_err   <= 1'b0;
          end
        end
        ST_LOAD: begin
`ifdef SW_MAX_TGT_CHECK_EN
          if (accept && over) begin
            // Overlong target: stop forwarding, swallow the rest.
            state     <= ST_RESULT;
            res_err   <= 1'b1;
            res_score <= ZERO;
            drop      <= !tgt_last;
            tgt_ready <= !tgt_last;
            res_valid <= tgt_last;
          end else
`endif
          if (accept) begin
            sa_en   <= 1'b1;
            sa_data <= tgt_data;
            if (res_len != '1) begin
              res_len <= res_len + 1'b1;
            end
            if (tgt_last) begin
              state     <= ST_DRAIN;
              tgt_ready <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (sa_vld) begin
            state     <= ST_RESULT;
            res_score <= sa_result;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
          end else if (tmr_zero) begin
            state     <= ST_RESULT;
            res_score <= ZERO;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
          end
        end
        ST_RESULT: begin
`ifdef SW_MAX_TGT_CHECK_EN
          if (drop && accept && tgt_last) begin
            drop      <= 1'b0;
            tgt_ready <= 1'b0;
            res_valid <= 1'b1;
          end
`endif
          if (res_valid && res_ready) begin
            state     <= ST_IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
